// File: rtl/cpu_alu_mdu_pkg.sv
// Shared decode constants and FSM state type for the cpu_alu_mdu execute unit.
package cpu_alu_mdu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SL   = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] MOD_BASE   = 7'b0000000;
  localparam logic [6:0] MOD_ALT    = 7'b0100000;
  localparam logic [6:0] MOD_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_alu_mdu_if.sv
// Request/response handshake bundle between operand select, the ALU/MDU and writeback.
interface cpu_alu_mdu_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      operation;
  logic [6:0]      mod;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            invalid_opcode;
  logic            div_by_zero;

  modport master (
    output in_valid, operation, mod, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, invalid_opcode, div_by_zero
  );

  modport slave (
    input  in_valid, operation, mod, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, invalid_opcode, div_by_zero
  );
endinterface

// File: rtl/cpu_alu_mdu_iter.sv
// One-bit-per-cycle shift/add (multiply) and shift/subtract (restoring divide) datapath.
module cpu_alu_mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            last_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  localparam int unsigned CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opd_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]    ain, mul_base;
  logic [XLEN+1:0]  addend, sum;

  // One adder serves both: hi+mcand for multiply, {hi,msb(lo)}-divisor for divide.
  always_comb begin
    ain      = div_q ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
    addend   = div_q ? ~{2'b00, opd_q} : {2'b00, opd_q};
    sum      = {1'b0, ain} + addend + {{(XLEN+1){1'b0}}, div_q};
    mul_base = lo_q[0] ? sum[XLEN:0] : ain;
    if (div_q) begin
      hi_d = sum[XLEN+1] ? ain[XLEN-1:0] : sum[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ~sum[XLEN+1]};
    end else begin
      hi_d = mul_base[XLEN:1];
      lo_d = {mul_base[0], lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opd_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      hi_q  <= '0;
      lo_q  <= a_i;
      opd_q <= b_i;
      div_q <= is_div_i;
      cnt_q <= '0;
    end else if (step_i) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign last_o = step_i && (cnt_q == CNT_W'(XLEN - 1));
  assign hi_o   = hi_d;
  assign lo_o   = lo_d;
endmodule

// File: rtl/cpu_alu_mdu.sv
// RV32I ALU + RV32M multiply/divide execute unit with valid/ready handshakes.
// Define CPU_ALU_MDU_FAST_MUL_EN for single-cycle combinational MUL* ops.
module cpu_alu_mdu
  import cpu_alu_mdu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input logic          clk,
  input logic          rst_n,
  cpu_alu_mdu_if.slave bus
);
  localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [XLEN-1:0]     a, b, mag_a, mag_b, alu_res, sra_res, single_res, iter_res, mul_res;
  logic [XLEN-1:0]     div_word, result_q, result_d, it_hi, it_lo;
  logic [2:0]          op;
  logic [6:0]          md;
  logic [SHAMT_W-1:0]  shamt;
  logic is_m, is_div, invalid, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, mul_single;
  logic iter_op, in_ready, accept, it_start, it_step, it_last;
  logic inv_q, inv_d, dbz_q, dbz_d, fix_neg_q, fix_hi_q, fix_div_q;

  function automatic logic [XLEN-1:0] mul_word(input logic [2*XLEN-1:0] p, input logic neg,
                                               input logic hi);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return hi ? s[2*XLEN-1:XLEN] : s[XLEN-1:0];
  endfunction

  assign a     = bus.operand_a;
  assign b     = bus.operand_b;
  assign op    = bus.operation;
  assign md    = bus.mod;
  assign shamt = b[SHAMT_W-1:0];

  assign is_m     = (md == MOD_MULDIV);
  assign invalid  = !((md == MOD_BASE) || is_m || ((md == MOD_ALT) && (op == F3_ADD || op == F3_SR)));
  assign is_div   = is_m && op[2];
  // Divides: both signed unless the U variant; multiplies: MULHU none, MULHSU only a.
  assign a_sgn    = op[2] ? ~op[0] : ~(op[1] & op[0]);
  assign b_sgn    = op[2] ? ~op[0] : ~op[1];
  assign a_neg    = a_sgn & a[XLEN-1];
  assign b_neg    = b_sgn & b[XLEN-1];
  assign mag_a    = a_neg ? -a : a;
  assign mag_b    = b_neg ? -b : b;
  assign div_zero = is_div && (b == '0);
  assign div_ovf  = is_div && ~op[0] && (a == MIN_V) && (b == '1);

`ifdef CPU_ALU_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign mul_res    = mul_word(fast_prod, a_neg ^ b_neg, op[1:0] != 2'b00);
  assign mul_single = 1'b1;
`else
  assign mul_res    = '0;
  assign mul_single = 1'b0;
`endif

  assign iter_op  = !invalid && is_m && (op[2] ? !(div_zero || div_ovf) : !mul_single);
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign it_start = accept && iter_op;
  assign it_step  = (state_q == ST_BUSY);
  assign sra_res  = $signed(a) >>> shamt;

  cpu_alu_mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (it_start),
    .step_i   (it_step),
    .is_div_i (is_div),
    .a_i      (mag_a),
    .b_i      (mag_b),
    .last_o   (it_last),
    .hi_o     (it_hi),
    .lo_o     (it_lo)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      F3_ADD:  alu_res = (md == MOD_ALT) ? a - b : a + b;
      F3_SL:   alu_res = a << shamt;
      F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      F3_XOR:  alu_res = a ^ b;
      F3_SR:   alu_res = (md == MOD_ALT) ? sra_res : a >> shamt;
      F3_OR:   alu_res = a | b;
      F3_AND:  alu_res = a & b;
      default: alu_res = '0;
    endcase
    // Overflow quotient is MIN, which is operand a itself.
    if (invalid)     single_res = '0;
    else if (is_div) single_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    else if (is_m)   single_res = mul_res;
    else             single_res = alu_res;
  end

  always_comb begin
    div_word = fix_hi_q ? it_hi : it_lo;
    iter_res = fix_div_q ? (fix_neg_q ? -div_word : div_word)
                         : mul_word({it_hi, it_lo}, fix_neg_q, fix_hi_q);
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    inv_d    = inv_q;
    dbz_d    = dbz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept)                                           state_d = iter_op ? ST_BUSY : ST_DONE;
        else if ((state_q == ST_DONE) && bus.out_ready)       state_d = ST_IDLE;
      end
      ST_BUSY: if (it_last) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (accept && !iter_op) begin
      result_d = single_res;
      inv_d    = invalid;
      dbz_d    = div_zero;
    end else if (accept) begin
      inv_d = 1'b0;
      dbz_d = 1'b0;
    end else if (it_last) begin
      result_d = iter_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      inv_q     <= 1'b0;
      dbz_q     <= 1'b0;
      fix_neg_q <= 1'b0;
      fix_hi_q  <= 1'b0;
      fix_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      inv_q    <= inv_d;
      dbz_q    <= dbz_d;
      if (it_start) begin
        fix_neg_q <= (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
        fix_hi_q  <= op[2] ? op[1] : (op[1:0] != 2'b00);
        fix_div_q <= op[2];
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = (state_q == ST_DONE);
  assign bus.result         = result_q;
  assign bus.invalid_opcode = inv_q;
  assign bus.div_by_zero    = dbz_q;
endmodule
